// File: rtl/spike_queue_dispatcher.sv
// Spike queue dispatcher: drains the external and auxiliary spike queues for the
// current biological time step in timestamp order. Each spike goes to the
// synapse/neuron update stage over a valid/ready handshake.
// Optional per-source dispatch counters are built when SPIKE_DISPATCH_STATS_EN
// is defined.
module spike_queue_dispatcher #(
    parameter int unsigned NEURON_WIDTH = 11,
    parameter int unsigned BT_WIDTH     = 36,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    DispatchEnable,
    input  logic [BT_WIDTH-1:0]     Current_BT,
    input  logic                    ExtIsQueueEmpty,
    input  logic [BT_WIDTH-1:0]     ExtBT_Head,
    input  logic [BT_WIDTH-1:0]     ExtBTOut,
    input  logic [NEURON_WIDTH-1:0] ExtNIDOut,
    output logic                    ExtDequeue,
    input  logic                    AuxIsQueueEmpty,
    input  logic [BT_WIDTH-1:0]     AuxBT_Head,
    input  logic [BT_WIDTH-1:0]     AuxBTOut,
    input  logic [NEURON_WIDTH-1:0] AuxNIDOut,
    output logic                    AuxDequeue,
    output logic                    SpikeValid,
    input  logic                    SpikeReady,
    output logic [NEURON_WIDTH-1:0] SpikeNID,
    output logic [BT_WIDTH-1:0]     SpikeBT,
    output logic                    SpikeSource,
    output logic                    DispatchComplete
`ifdef SPIKE_DISPATCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   ExtDispatchCount,
    output logic [STAT_WIDTH-1:0]   AuxDispatchCount,
    output logic [STAT_WIDTH-1:0]   StepDispatchCount
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPop,
        StCapture,
        StPresent,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic                    src_q, src_d;     // source chosen in SELECT: 0 ext, 1 aux
    logic                    rr_q, rr_d;       // tie-break pointer: 0 ext, 1 aux
    logic [NEURON_WIDTH-1:0] nid_q, nid_d;
    logic [BT_WIDTH-1:0]     bt_q, bt_d;
    logic                    spk_src_q, spk_src_d;

    logic ext_elig, aux_elig;
    logic ext_deq, aux_deq, valid, complete;

    assign ext_elig = !ExtIsQueueEmpty && (ExtBT_Head <= Current_BT);
    assign aux_elig = !AuxIsQueueEmpty && (AuxBT_Head <= Current_BT);

    // State and spike holding registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            src_q     <= 1'b0;
            rr_q      <= 1'b0;
            nid_q     <= '0;
            bt_q      <= '0;
            spk_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            rr_q      <= rr_d;
            nid_q     <= nid_d;
            bt_q      <= bt_d;
            spk_src_q <= spk_src_d;
        end
    end

    // Next-state, source arbitration and per-state strobes
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        rr_d      = rr_q;
        nid_d     = nid_q;
        bt_d      = bt_q;
        spk_src_d = spk_src_q;
        ext_deq   = 1'b0;
        aux_deq   = 1'b0;
        valid     = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (DispatchEnable) state_d = StSelect;
            end
            StSelect: begin
                if (!ext_elig && !aux_elig) begin
                    state_d = StDone;
                end else begin
                    state_d = StPop;
                    if (ext_elig && !aux_elig) begin
                        src_d = 1'b0;
                    end else if (aux_elig && !ext_elig) begin
                        src_d = 1'b1;
                    end else if (ExtBT_Head < AuxBT_Head) begin
                        src_d = 1'b0;
                    end else if (AuxBT_Head < ExtBT_Head) begin
                        src_d = 1'b1;
                    end else begin
                        // Equal timestamps: alternate sources across ties
                        src_d = rr_q;
                        rr_d  = !rr_q;
                    end
                end
            end
            StPop: begin
                ext_deq = !src_q;
                aux_deq = src_q;
                state_d = StCapture;
            end
            StCapture: begin
                // Popped data is valid the cycle after the dequeue strobe
                nid_d     = src_q ? AuxNIDOut : ExtNIDOut;
                bt_d      = src_q ? AuxBTOut : ExtBTOut;
                spk_src_d = src_q;
                state_d   = StPresent;
            end
            StPresent: begin
                valid = 1'b1;
                if (SpikeReady) state_d = StSelect;
            end
            StDone: begin
                complete = 1'b1;
                if (!DispatchEnable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate strobes with Reset so no pop can escape in a reset cycle
    assign ExtDequeue       = ext_deq && !Reset;
    assign AuxDequeue       = aux_deq && !Reset;
    assign SpikeValid       = valid && !Reset;
    assign DispatchComplete = complete && !Reset;
    assign SpikeNID         = nid_q;
    assign SpikeBT          = bt_q;
    assign SpikeSource      = spk_src_q;

`ifdef SPIKE_DISPATCH_STATS_EN
    logic [STAT_WIDTH-1:0] ext_cnt_q, aux_cnt_q, step_cnt_q;
    logic                  hs;

    assign hs = (state_q == StPresent) && SpikeReady;

    // Saturating dispatch counters; the step count restarts on each new step
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ext_cnt_q  <= '0;
            aux_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            if (hs && !spk_src_q && (ext_cnt_q != '1)) ext_cnt_q <= ext_cnt_q + 1'b1;
            if (hs && spk_src_q && (aux_cnt_q != '1)) aux_cnt_q <= aux_cnt_q + 1'b1;
            if ((state_q == StIdle) && DispatchEnable) begin
                step_cnt_q <= '0;
            end else if (hs && (step_cnt_q != '1)) begin
                step_cnt_q <= step_cnt_q + 1'b1;
            end
        end
    end

    assign ExtDispatchCount  = ext_cnt_q;
    assign AuxDispatchCount  = aux_cnt_q;
    assign StepDispatchCount = step_cnt_q;
`endif

endmodule
